// File: rtl/operand_wait_station_pkg.sv
// operand_wait_station_pkg: shared tag layout, slot states and modifier encodings
package operand_wait_station_pkg;
  localparam int RS_NONE = 0;
  localparam int TAG_SIGN_LO = 0;
  localparam logic [1:0] SCALE_OFF = 2'b00;
  localparam logic [1:0] SCALE_SHL = 2'b01;
  localparam logic [1:0] SCALE_SHR = 2'b11;
  typedef enum logic [1:0] {S_FREE, S_WAIT, S_READY} slot_state_t;
  function automatic int tag_swz_lo(int lanes);
    return lanes;
  endfunction
  function automatic int tag_scale_lo(int lanes);
    return 3 * lanes;
  endfunction
endpackage

// File: rtl/operand_wait_station_modifier.sv
// operand_modifier_unit: per-lane sign, scale and swizzle applied to one operand
module operand_modifier_unit import operand_wait_station_pkg::*; #(
  parameter int LANES = 3,
  parameter int LANE_W = 32,
  parameter int SCALE_SHIFT = 16,
  localparam int TAG_W = 3 * LANES + 2
) (
  input  logic [TAG_W-1:0]        tag,
  input  logic [LANES*LANE_W-1:0] din,
  output logic [LANES*LANE_W-1:0] dout
);
  localparam int SWZ_LO = tag_swz_lo(LANES);
  localparam int SCALE_LO = tag_scale_lo(LANES);
  logic [1:0] sc;
  logic [LANE_W-1:0] lane [4];
  assign sc = tag[SCALE_LO +: 2];
  for (genvar i = 0; i < 4; i++) begin : g_lane
    if (i < LANES) begin : g_on
      logic [LANE_W-1:0] sg, shl;
      logic signed [LANE_W-1:0] sra;
      logic [1:0] sel;
      assign sg = tag[TAG_SIGN_LO + i] ? -din[i*LANE_W +: LANE_W] : din[i*LANE_W +: LANE_W];
      assign shl = sg << SCALE_SHIFT;
      assign sra = $signed(sg) >>> SCALE_SHIFT;
      assign lane[i] = sc == SCALE_SHR ? sra : sc == SCALE_SHL ? shl : sg;
      assign sel = tag[SWZ_LO + 2*i +: 2];
      assign dout[i*LANE_W +: LANE_W] = int'(sel) < LANES ? lane[sel] : lane[i];
    end else begin : g_off
      assign lane[i] = '0;
    end
  end
endmodule

// File: rtl/operand_wait_station.sv
// operand_wait_station: operand wait slots with commit capture, round-robin forwarding and modifiers
module operand_wait_station import operand_wait_station_pkg::*; #(
  parameter int SLOTS = 4,
  parameter int LANES = 3,
  parameter int LANE_W = 32,
  parameter int RS_W = 4,
  parameter int SCALE_SHIFT = 16,
  localparam int TAG_W = 3 * LANES + 2,
  localparam int DW = LANES * LANE_W,
  localparam int IW = $clog2(SLOTS),
  localparam int CW = $clog2(SLOTS + 1)
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                iIssueValid,
  input  logic [2*RS_W-1:0]   iSrcRs,
  input  logic [2*TAG_W-1:0]  iSrcTag,
  output logic                oStall,
  input  logic                iCommitValid,
  input  logic [RS_W-1:0]     iCommitRs,
  input  logic [DW-1:0]       iCommitData,
  input  logic                iBusFree,
  output logic                oFwdValid,
  output logic [RS_W-1:0]     oFwdRs,
  output logic [TAG_W-1:0]    oFwdTag,
  output logic [DW-1:0]       oFwdData,
  output logic [CW-1:0]       oOccupancy
);
  slot_state_t st [SLOTS];
  logic [RS_W-1:0] rs [SLOTS];
  logic [TAG_W-1:0] tag [SLOTS];
  logic [DW-1:0] data [SLOTS];
  logic [IW-1:0] rot [SLOTS];
  logic [IW-1:0] rr_ptr, gnt;
  logic [SLOTS-1:0] fr, fr1, rd, ff0, ff1, a0_oh, a1_oh, gnt_oh;
  logic [RS_W-1:0] rs0, rs1;
  logic [TAG_W-1:0] tag0, tag1, gtag;
  logic [DW-1:0] gdata, mdata;
  logic need0, need1, go, hit, found, gnt_v;
  logic [1:0] demand;
  logic [CW-1:0] free_cnt;
  assign {rs1, rs0} = iSrcRs;
  assign {tag1, tag0} = iSrcTag;
  assign need0 = rs0 != RS_W'(RS_NONE);
  assign need1 = rs1 != RS_W'(RS_NONE);
  assign demand = iIssueValid ? 2'(need0) + 2'(need1) : 2'd0;
  assign free_cnt = CW'($countones(fr));
  assign oStall = iIssueValid && free_cnt < CW'(demand);
  assign oOccupancy = CW'(SLOTS) - free_cnt;
  assign go = iIssueValid && !oStall;
  assign hit = iCommitValid && iCommitRs != RS_W'(RS_NONE);
  assign ff0 = fr & (~fr + SLOTS'(1));
  assign fr1 = fr & ~ff0;
  assign ff1 = fr1 & (~fr1 + SLOTS'(1));
  assign a0_oh = go && need0 ? ff0 : '0;
  assign a1_oh = go && need1 ? (need0 ? ff1 : ff0) : '0;
  assign gnt_v = found && iBusFree;
  assign gnt_oh = gnt_v ? SLOTS'(1) << gnt : '0;
  assign gtag = tag[gnt];
  assign gdata = data[gnt];
  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    assign fr[i] = st[i] == S_FREE;
    assign rd[i] = st[i] == S_READY;
    assign rot[i] = IW'((32'(rr_ptr) + i) % SLOTS);
  end
  // first READY slot in priority order starting at rr_ptr
  always_comb begin
    found = 1'b0;
    gnt = '0;
    for (int k = 0; k < SLOTS; k++)
      if (!found && rd[rot[k]]) begin
        found = 1'b1;
        gnt = rot[k];
      end
  end
  operand_modifier_unit #(
    .LANES(LANES),
    .LANE_W(LANE_W),
    .SCALE_SHIFT(SCALE_SHIFT)
  ) u_mod (
    .tag(gtag),
    .din(gdata),
    .dout(mdata)
  );
  // slot lifecycle (release, wake-up, allocation), RR pointer and registered forward output
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int k = 0; k < SLOTS; k++) begin
        st[k] <= S_FREE;
        rs[k] <= '0;
        tag[k] <= '0;
        data[k] <= '0;
      end
      rr_ptr <= '0;
      oFwdValid <= 1'b0;
      oFwdRs <= '0;
      oFwdTag <= '0;
      oFwdData <= '0;
    end else begin
      for (int k = 0; k < SLOTS; k++) begin
        if (gnt_oh[k]) st[k] <= S_FREE;
        else if (st[k] == S_WAIT && hit && rs[k] == iCommitRs) begin
          st[k] <= S_READY;
          data[k] <= iCommitData;
        end else if (a0_oh[k] || a1_oh[k]) begin
          rs[k] <= a0_oh[k] ? rs0 : rs1;
          tag[k] <= a0_oh[k] ? tag0 : tag1;
          st[k] <= hit && (a0_oh[k] ? rs0 : rs1) == iCommitRs ? S_READY : S_WAIT;
          data[k] <= iCommitData;
        end
      end
      if (gnt_v) rr_ptr <= gnt == IW'(SLOTS - 1) ? '0 : gnt + 1'b1;
      oFwdValid <= gnt_v;
      if (gnt_v) begin
        oFwdRs <= rs[gnt];
        oFwdTag <= gtag;
        oFwdData <= mdata;
      end
    end
  end
endmodule

// File: tb/tb_operand_wait_station.sv
// tb_operand_wait_station: table-driven modifier vectors plus scoreboarded multi-cycle sequences
module tb_operand_wait_station;
  localparam int SLOTS = 4, LANES = 3, LANE_W = 32, RS_W = 4, TAG_W = 11, DW = 96, CW = 3;
  logic clk = 1'b0, rst = 1'b1;
  logic iIssueValid, iCommitValid, iBusFree;
  logic [2*RS_W-1:0] iSrcRs;
  logic [2*TAG_W-1:0] iSrcTag;
  logic [RS_W-1:0] iCommitRs;
  logic [DW-1:0] iCommitData;
  logic oStall, oFwdValid;
  logic [RS_W-1:0] oFwdRs;
  logic [TAG_W-1:0] oFwdTag;
  logic [DW-1:0] oFwdData;
  logic [CW-1:0] oOccupancy;
  typedef struct packed {
    logic [RS_W-1:0] rs;
    logic [TAG_W-1:0] tag;
    logic [DW-1:0] data;
  } fwd_t;
  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
  } vec_t;
  fwd_t exp_q[$];
  vec_t vt [8];
  int checks = 0, errors = 0;
  logic [TAG_W-1:0] t_id, t_neg0, t_sc;
  operand_wait_station #(
    .SLOTS(SLOTS), .LANES(LANES), .LANE_W(LANE_W), .RS_W(RS_W), .SCALE_SHIFT(16)
  ) dut (
    .Clock(clk), .Reset(rst), .iIssueValid(iIssueValid), .iSrcRs(iSrcRs), .iSrcTag(iSrcTag),
    .oStall(oStall), .iCommitValid(iCommitValid), .iCommitRs(iCommitRs), .iCommitData(iCommitData),
    .iBusFree(iBusFree), .oFwdValid(oFwdValid), .oFwdRs(oFwdRs), .oFwdTag(oFwdTag),
    .oFwdData(oFwdData), .oOccupancy(oOccupancy)
  );
  always #5 clk = ~clk;
  function automatic logic [TAG_W-1:0] mk(logic [1:0] sc, logic [5:0] swz, logic [2:0] sg);
    return {sc, swz, sg};
  endfunction
  function automatic logic [DW-1:0] mkd(int r);
    return {32'(r) + 32'h200, 32'(r) + 32'h100, 32'(r)};
  endfunction
  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic push(logic [RS_W-1:0] r, logic [TAG_W-1:0] t, logic [DW-1:0] d);
    fwd_t e;
    e.rs = r;
    e.tag = t;
    e.data = d;
    exp_q.push_back(e);
  endtask
  task automatic idle();
    iIssueValid = 1'b0;
    iSrcRs = '0;
    iSrcTag = '0;
    iCommitValid = 1'b0;
    iCommitRs = '0;
    iCommitData = '0;
  endtask
  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic drain(string name);
    for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(negedge clk);
    check(name, exp_q.size(), 0);
  endtask
  // scoreboard: every forward must match the oldest expected entry
  always @(negedge clk) begin
    fwd_t e;
    if (!rst && oFwdValid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_fwd: got rs %0d data %0h, expected no output", oFwdRs, oFwdData);
      end else begin
        e = exp_q.pop_front();
        check("fwd_rs", oFwdRs, e.rs);
        check("fwd_tag", oFwdTag, e.tag);
        check("fwd_data", oFwdData, e.data);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
  initial begin
    t_id = mk(2'b00, 6'b111111, 3'b000);
    t_neg0 = mk(2'b00, 6'b111111, 3'b001);
    t_sc = mk(2'b11, 6'b111111, 3'b000);
    vt[0] = '{mk(2'b00, 6'b111111, 3'b001), {32'd3, 32'd2, 32'd1}, {32'd3, 32'd2, 32'hFFFFFFFF}};
    vt[1] = '{mk(2'b11, 6'b111111, 3'b000), {32'h80000000, 32'h00010000, 32'hFFFF0000}, {32'hFFFF8000, 32'h00000001, 32'hFFFFFFFF}};
    vt[2] = '{mk(2'b01, 6'b111111, 3'b000), {32'h1234ABCD, 32'h0000FFFF, 32'h00000001}, {32'hABCD0000, 32'hFFFF0000, 32'h00010000}};
    vt[3] = '{mk(2'b00, 6'b000000, 3'b000), {32'd30, 32'd20, 32'd10}, {32'd10, 32'd10, 32'd10}};
    vt[4] = '{mk(2'b00, 6'b000110, 3'b000), {32'd30, 32'd20, 32'd10}, {32'd10, 32'd20, 32'd30}};
    vt[5] = '{mk(2'b10, 6'b111101, 3'b010), {32'd7, 32'd5, 32'd3}, {32'd7, 32'hFFFFFFFB, 32'hFFFFFFFB}};
    vt[6] = '{mk(2'b11, 6'b111111, 3'b100), {32'h00020000, 32'h00050000, 32'h00050000}, {32'hFFFFFFFE, 32'd5, 32'd5}};
    vt[7] = '{mk(2'b01, 6'b111111, 3'b111), {32'd1, 32'd2, 32'd3}, {32'hFFFF0000, 32'hFFFE0000, 32'hFFFD0000}};
    idle();
    iBusFree = 1'b1;
    cyc(2);
    check("rst_valid", oFwdValid, 0);
    check("rst_rs", oFwdRs, 0);
    check("rst_data", oFwdData, 0);
    check("rst_occ", oOccupancy, 0);
    check("rst_stall", oStall, 0);
    rst = 1'b0;
    cyc(1);
    iIssueValid = 1'b1;
    iSrcRs = {4'd0, 4'd5};
    iSrcTag = {11'd0, t_neg0};
    cyc(1);
    idle();
    iCommitValid = 1'b1;
    iCommitRs = 4'd5;
    iCommitData = {32'd3, 32'd2, 32'd1};
    push(4'd5, t_neg0, {32'd3, 32'd2, 32'hFFFFFFFF});
    cyc(1);
    idle();
    check("t1_valid_early", oFwdValid, 0);
    check("t1_occ_ready", oOccupancy, 1);
    cyc(1);
    check("t1_valid", oFwdValid, 1);
    check("t1_occ_after", oOccupancy, 0);
    drain("t1_drain");
    for (int i = 0; i < 8; i++) begin
      iIssueValid = 1'b1;
      iSrcRs = {4'd0, 4'(i + 1)};
      iSrcTag = {11'd0, vt[i].tag};
      cyc(1);
      idle();
      iCommitValid = 1'b1;
      iCommitRs = 4'(i + 1);
      iCommitData = vt[i].din;
      push(4'(i + 1), vt[i].tag, vt[i].dout);
      cyc(1);
      idle();
      drain("vec_drain");
    end
    iIssueValid = 1'b1;
    iSrcRs = {4'd2, 4'd1};
    iSrcTag = {t_id, t_id};
    cyc(1);
    iSrcRs = {4'd4, 4'd3};
    cyc(1);
    iSrcRs = {4'd0, 4'd6};
    iSrcTag = {11'd0, t_id};
    #1;
    check("full_occ", oOccupancy, 4);
    check("full_stall", oStall, 1);
    iCommitValid = 1'b1;
    iCommitRs = 4'd3;
    iCommitData = mkd(3);
    push(4'd3, t_id, mkd(3));
    cyc(1);
    iCommitValid = 1'b0;
    #1;
    check("stall_occ_hold", oOccupancy, 4);
    check("stall_hold", oStall, 1);
    cyc(1);
    #1;
    check("stall_occ_freed", oOccupancy, 3);
    check("stall_drop", oStall, 0);
    cyc(1);
    idle();
    iBusFree = 1'b0;
    check("realloc_occ", oOccupancy, 4);
    for (int r = 1; r <= 4; r++) if (r != 3) begin
      iCommitValid = 1'b1;
      iCommitRs = 4'(r);
      iCommitData = mkd(r);
      cyc(1);
    end
    idle();
    push(4'd4, t_id, mkd(4));
    push(4'd1, t_id, mkd(1));
    push(4'd2, t_id, mkd(2));
    for (int k = 0; k < 10; k++) begin
      check("hold_valid", oFwdValid, 0);
      check("hold_occ", oOccupancy, 4);
      cyc(1);
    end
    iBusFree = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      check("release_valid", oFwdValid, 1);
    end
    cyc(1);
    check("release_done", oFwdValid, 0);
    check("release_occ", oOccupancy, 1);
    iCommitValid = 1'b1;
    iCommitRs = 4'd6;
    iCommitData = mkd(6);
    push(4'd6, t_id, mkd(6));
    cyc(1);
    idle();
    drain("hold_drain");
    iIssueValid = 1'b1;
    iSrcRs = {4'd7, 4'd7};
    iSrcTag = {t_id, t_neg0};
    cyc(1);
    idle();
    iCommitValid = 1'b1;
    iCommitRs = 4'd7;
    iCommitData = {32'd3, 32'd2, 32'd1};
    push(4'd7, t_neg0, {32'd3, 32'd2, 32'hFFFFFFFF});
    push(4'd7, t_id, {32'd3, 32'd2, 32'd1});
    cyc(1);
    idle();
    check("dual_early", oFwdValid, 0);
    check("dual_occ", oOccupancy, 2);
    cyc(1);
    check("dual_first", oFwdValid, 1);
    cyc(1);
    check("dual_second", oFwdValid, 1);
    cyc(1);
    check("dual_end", oFwdValid, 0);
    drain("dual_drain");
    iIssueValid = 1'b1;
    iSrcRs = {4'd0, 4'd9};
    iSrcTag = {11'd0, t_sc};
    iCommitValid = 1'b1;
    iCommitRs = 4'd9;
    iCommitData = {32'd0, 32'd0, 32'hFFFF0000};
    push(4'd9, t_sc, {32'd0, 32'd0, 32'hFFFFFFFF});
    cyc(1);
    idle();
    check("bypass_occ", oOccupancy, 1);
    check("bypass_early", oFwdValid, 0);
    cyc(1);
    check("bypass_valid", oFwdValid, 1);
    drain("bypass_drain");
    iIssueValid = 1'b1;
    iSrcRs = {4'd11, 4'd10};
    iSrcTag = {t_id, t_id};
    cyc(1);
    idle();
    iCommitValid = 1'b1;
    iCommitRs = 4'd10;
    iCommitData = mkd(10);
    cyc(1);
    idle();
    rst = 1'b1;
    cyc(1);
    check("mid_rst_valid", oFwdValid, 0);
    check("mid_rst_rs", oFwdRs, 0);
    check("mid_rst_tag", oFwdTag, 0);
    check("mid_rst_data", oFwdData, 0);
    check("mid_rst_occ", oOccupancy, 0);
    rst = 1'b0;
    cyc(1);
    check("post_rst_occ", oOccupancy, 0);
    check("post_rst_valid", oFwdValid, 0);
    iIssueValid = 1'b1;
    iSrcRs = {4'd0, 4'd12};
    iSrcTag = {11'd0, t_id};
    cyc(1);
    idle();
    iCommitValid = 1'b1;
    iCommitRs = 4'd12;
    iCommitData = mkd(12);
    push(4'd12, t_id, mkd(12));
    cyc(1);
    idle();
    drain("post_rst_drain");
    cyc(3);
    check("final_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
